serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial add/subtract engine: accepts two WIDTH-bit operands over a valid/ready handshake and sequences them LSB-first through a single 1-bit full adder cell, one bit per clock, with a registered carry. Returns the WIDTH-bit result plus carry-out and signed-overflow flags over a second valid/ready handshake. Sits between a requester and the shared 1-bit arithmetic cell, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored for subtract
- op_sub  input  1  0 = A+B+cin, 1 = A−B
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry-out (for subtract: 1 = no borrow)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: latch a into shift reg A; latch (op_sub ? ~b : b) into shift reg B; load carry reg with (op_sub ? 1 : cin); clear bit counter and result reg; go to RUN.
- RUN: full adder inputs = A[0], B[0], carry reg. Each edge: shift A and B right by one; shift the sum bit into the result reg at MSB, shifting the result reg right; carry reg ← adder cout; capture the carry reg value into ovf_pre when counter = WIDTH−1 (carry into MSB); increment counter. After the edge with counter = WIDTH−1, go to DONE.
- DONE: out_valid=1. sum = result reg, cout = carry reg, ovf = ovf_pre XOR carry reg. All held stable until out_ready. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored; operands are not buffered.
- Result wraps modulo 2^WIDTH; wrap is reported only through cout and ovf.
- Reset (any state, any cycle): state=IDLE; counter, shift regs, carry, result, and ovf_pre all cleared; any in-flight operation is discarded with no output.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, busy=0.
- Accept edge E0. RUN occupies the WIDTH cycles after E0. out_valid rises after edge E0+WIDTH. Latency = WIDTH cycles from accept to result.
- in_ready, out_valid, and busy decode the state register only; they have no combinational path from any input.
- out_valid&out_ready at edge Ek moves to IDLE. in_ready rises after Ek; the next accept can occur no earlier than Ek+1.
- Maximum throughput is one operation per WIDTH+2 cycles with out_ready held high.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes; the operand is not taken.

## Structure
- Shared package (serial_arith_pkg): state enum (IDLE/RUN/DONE) and the op_sub encoding constants.
- Counter width is $clog2(WIDTH).
- One sub-module: instantiate the team's dataflow 1-bit full adder (full_adder_df) as the only arithmetic cell. The controller adds no other adder logic.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> after 8 cycles sum=0x96, cout=0, ovf=1.
- Add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Subtract, a=0x10, b=0x20, cin=1 (ignored) -> sum=0xF0, cout=0, ovf=0; a=0x20, b=0x10 -> sum=0x10, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> sum/cout/ovf stable, in_ready=0, no new accept; after out_ready, in_ready=1 on the next cycle.
- Deassert rst_n mid-RUN after bit 3 -> outputs go to reset values immediately, out_valid never asserts for that operation; the next operation (0x01+0x01) returns 0x02.
- Random back-to-back traffic with random out_ready, checked against a+b+cin and a−b models -> every result is exact and the accept-to-result latency is always WIDTH cycles.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_df.sv
// Dataflow 1-bit full adder cell; the only arithmetic element of the serial engine.
module full_adder_df (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: feeds operands LSB-first through one full adder,
// one bit per clock, and returns sum/cout/ovf over a valid/ready handshake.
module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             ovf_pre;
    logic             fa_sum;
    logic             fa_cout;

    full_adder_df u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            ovf_pre <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        // Subtract is A + ~B + 1, so cin is ignored in that mode.
                        b_sh    <= (op_sub == OP_SUB) ? ~b : b;
                        carry   <= (op_sub == OP_SUB) ? 1'b1 : cin;
                        res     <= '0;
                        cnt     <= '0;
                        ovf_pre <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Carry entering the MSB, needed for signed overflow.
                        ovf_pre <= carry;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = res;
    assign cout      = carry;
    assign ovf       = ovf_pre ^ carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random traffic
// against an arithmetic reference model.
module tb_serial_adder_ctrl;
    import serial_arith_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = OP_ADD;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic s, output logic [W-1:0] rs, output logic rc,
                         output logic ro);
        longint ux, uy, sx, sy, ut, st, lim;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy  = y[W-1] ? uy - (longint'(1) << W) : uy;
        lim = longint'(1) << (W - 1);
        if (s) begin
            ut = ux - uy;
            st = sx - sy;
            rc = (ux >= uy);
        end else begin
            ut = ux + uy + longint'(c);
            st = sx + sy + longint'(c);
            rc = (ut >= (longint'(1) << W));
        end
        rs = W'(ut);
        ro = (st < -lim) || (st > lim - 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Issue one operation, check latency and result, then drain with hold cycles.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s, input logic [W-1:0] e_sum,
                          input logic e_cout, input logic e_ovf, input int hold);
        int lat = 0;
        wait_ready(tag);
        a = x; b = y; cin = c; op_sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 3 * W) begin
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(W));
        check_eq({tag, "_sum"}, 32'(sum), 32'(e_sum));
        check_eq({tag, "_cout"}, 32'(cout), 32'(e_cout));
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        for (int i = 0; i < hold; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_idle_after"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic [W-1:0] rx, ry, es, held_sum;
        logic rc, rs, ec, eo, held_cout, held_ovf;

        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_outs", 32'({sum, cout, ovf, busy}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, OP_ADD, 8'h96, 1'b0, 1'b1, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0, 1);
        run_op("add_7f_00c", 8'h7F, 8'h00, 1'b1, OP_ADD, 8'h80, 1'b0, 1'b1, 0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, OP_SUB, 8'hF0, 1'b0, 1'b0, 0);
        run_op("sub_20_10", 8'h20, 8'h10, 1'b0, OP_SUB, 8'h10, 1'b1, 1'b0, 2);

        // Backpressure in DONE with in_valid pulsing.
        wait_ready("bp");
        a = 8'h33; b = 8'h44; cin = 1'b0; op_sub = OP_ADD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) tick();
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_sum", 32'(sum), 32'h77);
        held_sum = sum; held_cout = cout; held_ovf = ovf;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = W'($urandom); b = W'($urandom);
            tick();
            check_eq("bp_hold_sum", 32'({sum, cout, ovf}), 32'({held_sum, held_cout, held_ovf}));
            check_eq("bp_hold_hs", 32'({in_ready, out_valid, busy}), 32'b011);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check_eq("bp_release", 32'({in_ready, out_valid, busy}), 32'b100);
        tick();
        check_eq("bp_no_accept", 32'({in_ready, busy}), 32'b10);

        // Reset mid-RUN.
        a = 8'hAB; b = 8'hCD; cin = 1'b1; op_sub = OP_ADD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_hs", 32'({in_ready, out_valid, busy}), 32'b100);
        check_eq("midrst_outs", 32'({sum, cout, ovf}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (out_valid) check_eq("midrst_spurious_valid", 32'(out_valid), 32'd0);
        end
        check_eq("midrst_idle", 32'({in_ready, busy}), 32'b10);
        run_op("post_rst_1p1", 8'h01, 8'h01, 1'b0, OP_ADD, 8'h02, 1'b0, 1'b0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            model(rx, ry, rc, rs, es, ec, eo);
            run_op("rand", rx, ry, rc, rs, es, ec, eo, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
